seg7_scan_decode_4: RTL
=======================

SEG7_SCAN_DECODE_4 -- requirements
Module: seg7_scan_decode_4

Interface
REQ-001 The block SHALL have parameter STABLE_CYCLES, default 16, giving the consecutive identical synchronized samples needed to accept a digit (legal 2..255).
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 65536, giving the maximum cycles between accepted digits before the frame is discarded (legal 16..2^24).
REQ-003 The block SHALL have port iCLK, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port iRST_N, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port iSEG, input, 7 bits: scanned segment lines, active-low; bit0=a through bit6=g.
REQ-006 The block SHALL have port iSEG_DP, input, 1 bit: scanned decimal point, active-low.
REQ-007 The block SHALL have port iDIG_SEL, input, 4 bits: digit enables, active-low; bit n selects digit n, and digit 0 is the least significant nibble.
REQ-008 The block SHALL have port oDIG, output, 16 bits: last complete decoded value, with digit n in bits [4n+3:4n].
REQ-009 The block SHALL have port oDP, output, 4 bits: decimal points of the last complete frame, active-high, with bit n for digit n.
REQ-010 The block SHALL have port oVALID, output, 1 bit: one-cycle pulse when oDIG/oDP are updated.
REQ-011 The block SHALL have port oERR, output, 1 bit: one-cycle pulse when an accepted digit holds a non-hex pattern.
REQ-012 The block SHALL have port oSTALE, output, 1 bit: level, high while no frame has completed since reset or since the last timeout.

Function
REQ-013 The block SHALL pass iSEG, iSEG_DP and iDIG_SEL through a 2-flop synchronizer; all decisions use the synchronized values.
REQ-014 The block SHALL decode the active-low patterns as follows: 0=0x40, 1=0x79, 2=0x24, 3=0x30, 4=0x19, 5=0x12, 6=0x02, 7=0x78, 8=0x00, 9=0x10, A=0x08, b=0x03, C=0x46, d=0x21, E=0x06, F=0x0E. All other patterns, including blank 0x7F, are invalid.
REQ-015 The block SHALL implement an FSM with the states IDLE, DWELL and HOLD.
- IDLE: exactly one iDIG_SEL bit is low -> latch {sel, seg, dp} as the reference sample, stable count=1, go to DWELL.
REQ-016 In DWELL, a sample equal to the reference SHALL increment the stable count, and a differing sample SHALL return the FSM to IDLE with the count cleared.
- A differing sample that still has exactly one select low SHALL be latched as the new reference in the same cycle, with count=1, staying in DWELL.
REQ-017 In DWELL, when the count reaches STABLE_CYCLES, the block SHALL accept the digit and go to HOLD.
- Valid pattern: store the nibble and the DP into that digit's holding slot, and set seen[n].
- Invalid pattern: leave the slot unchanged, clear seen to 0, and pulse oERR on the next cycle.
REQ-018 HOLD SHALL remain until the synchronized {sel, seg, dp} differs from the reference, then go to IDLE. A digit is therefore accepted at most once per dwell.
REQ-019 The cycle after seen becomes 4'b1111, the block SHALL copy the holding slots to oDIG/oDP, pulse oVALID for one cycle, clear seen, and clear oSTALE.
REQ-020 Re-accepting a digit whose seen bit is already set SHALL overwrite its slot. No frame completes until all four bits are set.
REQ-021 The timeout counter SHALL reset on every valid acceptance. When it reaches TIMEOUT_CYCLES, the block SHALL clear seen and set oSTALE. oDIG/oDP hold their last values.
REQ-022 Zero or multiple low select bits SHALL be treated as "no digit": DWELL/HOLD go to IDLE and nothing is accepted.
REQ-023 Latency from the first stable input sample to the oVALID pulse for the fourth digit SHALL be 2 (sync) + STABLE_CYCLES + 1 cycles.
REQ-024 If a completion and a timeout fall on the same cycle, the completion SHALL take priority: oVALID pulses and oSTALE clears.
REQ-025 oVALID and oERR SHALL never be asserted in the same cycle.

Reset
REQ-026 While iRST_N=0 at a rising edge, the block SHALL clear synchronizers, FSM=IDLE, counts, seen and slots; oDIG=16'h0000, oDP=4'b0000, oVALID=0, oERR=0, oSTALE=1.
REQ-027 Reset asserted mid-dwell or mid-frame SHALL discard partial data. No oVALID follows reset until four fresh digits are accepted.

Verification
REQ-028 Test 1, clean frame: scan digits 0..3 with patterns 0x30, 0x24, 0x79, 0x40 (3,2,1,0), each held 40 cycles with STABLE_CYCLES=16 -> one oVALID, oDIG=16'h0123, oDP=0, oSTALE falls.
REQ-029 Test 2, glitch: digit 2 pattern 0x08 interrupted by a 1-cycle 0x00 at count 10 -> count restarts, and the digit is accepted only after 16 further identical samples.
REQ-030 Test 3, invalid pattern: digit 1 shows 0x7F for 20 cycles -> oERR pulses once, seen clears, no oVALID until a full new frame arrives.
REQ-031 Test 4, select faults: iDIG_SEL=4'b1111 or 4'b0011 held 100 cycles -> no acceptance, no oVALID, no oERR.
REQ-032 Test 5, timeout: TIMEOUT_CYCLES=64, three digits accepted then inputs frozen at blank-select -> oSTALE=1 at 64 cycles after the last acceptance, and oDIG keeps its previous value.
REQ-033 Test 6, reset: reset pulsed after two digits accepted, then digits 2,3 only -> no oVALID. After a subsequent full frame, oVALID is asserted with the new value.

Source files
------------

// File: rtl/seg7_scan_decode_4.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : seg7_scan_decode_4                                      |
// | Brief  : decodes a scanned 4-digit active-low 7-seg bus to hex   |
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
module seg7_scan_decode_4 #(
  parameter int STABLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic [6:0]  iSEG,
  input  logic        iSEG_DP,
  input  logic [3:0]  iDIG_SEL,
  output logic [15:0] oDIG,
  output logic [3:0]  oDP,
  output logic        oVALID,
  output logic        oERR,
  output logic        oSTALE
);
  localparam int                 c_TMO_W       = $clog2(TIMEOUT_CYCLES);
  localparam logic [7:0]         c_STABLE_LAST = 8'(STABLE_CYCLES - 1);
  localparam logic [c_TMO_W-1:0] c_TMO_LAST    = c_TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DWELL = 2'd1,
    HOLD  = 2'd2
  } stateT;

  stateT              r_state;
  logic [11:0]        r_sync1, r_sync2, r_ref;   // {sel[3:0], seg[6:0], dp}
  logic [7:0]         r_stableCnt;
  logic [c_TMO_W-1:0] r_tmoCnt;
  logic [15:0]        r_holdDig, r_dig;
  logic [3:0]         r_holdDp, r_dp, r_seen;
  logic               r_valid, r_err, r_stale;

  logic [11:0] w_sample;
  logic        w_oneSel, w_hexOk, w_accept, w_acceptOk, w_timeout;
  logic [1:0]  w_refIdx;
  logic [3:0]  w_nibble;

  assign w_sample = r_sync2;

  always_comb begin
    w_oneSel = 1'b0;
    case (w_sample[11:8])
      4'b1110, 4'b1101, 4'b1011, 4'b0111: w_oneSel = 1'b1;
      default:                            w_oneSel = 1'b0;
    endcase
  end

  always_comb begin
    w_refIdx = 2'd0;
    case (r_ref[11:8])
      4'b1101: w_refIdx = 2'd1;
      4'b1011: w_refIdx = 2'd2;
      4'b0111: w_refIdx = 2'd3;
      default: w_refIdx = 2'd0;
    endcase
  end

  always_comb begin
    w_nibble = 4'h0;
    w_hexOk  = 1'b1;
    case (r_ref[7:1])
      7'h40: w_nibble = 4'h0;
      7'h79: w_nibble = 4'h1;
      7'h24: w_nibble = 4'h2;
      7'h30: w_nibble = 4'h3;
      7'h19: w_nibble = 4'h4;
      7'h12: w_nibble = 4'h5;
      7'h02: w_nibble = 4'h6;
      7'h78: w_nibble = 4'h7;
      7'h00: w_nibble = 4'h8;
      7'h10: w_nibble = 4'h9;
      7'h08: w_nibble = 4'hA;
      7'h03: w_nibble = 4'hB;
      7'h46: w_nibble = 4'hC;
      7'h21: w_nibble = 4'hD;
      7'h06: w_nibble = 4'hE;
      7'h0E: w_nibble = 4'hF;
      default: w_hexOk = 1'b0;
    endcase
  end

  assign w_accept   = (r_state == DWELL) && w_oneSel && (w_sample == r_ref) &&
                      (r_stableCnt == c_STABLE_LAST);
  assign w_acceptOk = w_accept && w_hexOk;
  assign w_timeout  = (r_tmoCnt == c_TMO_LAST);

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      r_sync1     <= 12'hFFF;
      r_sync2     <= 12'hFFF;
      r_ref       <= 12'hFFF;
      r_state     <= IDLE;
      r_stableCnt <= 8'd0;
      r_tmoCnt    <= '0;
      r_holdDig   <= 16'h0000;
      r_holdDp    <= 4'b0000;
      r_seen      <= 4'b0000;
      r_dig       <= 16'h0000;
      r_dp        <= 4'b0000;
      r_valid     <= 1'b0;
      r_err       <= 1'b0;
      r_stale     <= 1'b1;
    end else begin
      r_sync1 <= {iDIG_SEL, iSEG, iSEG_DP};
      r_sync2 <= r_sync1;
      r_valid <= 1'b0;
      r_err   <= 1'b0;

      case (r_state)
        IDLE: begin
          if (w_oneSel) begin
            r_ref       <= w_sample;
            r_stableCnt <= 8'd1;
            r_state     <= DWELL;
          end
        end
        DWELL: begin
          if (!w_oneSel) begin
            r_stableCnt <= 8'd0;
            r_state     <= IDLE;
          end else if (w_sample != r_ref) begin
            // a different but legal digit restarts the dwell on itself
            r_ref       <= w_sample;
            r_stableCnt <= 8'd1;
          end else if (w_accept) begin
            r_stableCnt <= 8'd0;
            r_state     <= HOLD;
          end else begin
            r_stableCnt <= r_stableCnt + 8'd1;
          end
        end
        HOLD: begin
          if (w_sample != r_ref) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase

      if (w_acceptOk) begin
        r_holdDig[{w_refIdx, 2'b00} +: 4] <= w_nibble;
        r_holdDp[w_refIdx]                <= ~r_ref[0];
      end

      // completion cannot coincide with an acceptance: the accepting edge enters HOLD
      if (r_seen == 4'b1111) begin
        r_dig   <= r_holdDig;
        r_dp    <= r_holdDp;
        r_valid <= 1'b1;
        r_stale <= 1'b0;
        r_seen  <= 4'b0000;
      end else if (w_acceptOk) begin
        r_seen <= r_seen | (4'b0001 << w_refIdx);
      end else if (w_accept || w_timeout) begin
        r_seen <= 4'b0000;
      end

      if (w_accept && !w_hexOk) r_err <= 1'b1;
      if (w_timeout && (r_seen != 4'b1111) && !w_acceptOk) r_stale <= 1'b1;

      if (w_acceptOk || w_timeout) r_tmoCnt <= '0;
      else                         r_tmoCnt <= r_tmoCnt + 1'b1;
    end
  end

  assign oDIG   = r_dig;
  assign oDP    = r_dp;
  assign oVALID = r_valid;
  assign oERR   = r_err;
  assign oSTALE = r_stale;
endmodule
`default_nettype wire
